mt_bram_arbiter: RTL and testbench

MT_BRAM_ARBITER -- requirements
Module: mt_bram_arbiter

---
 rtl/mt_bram_arbiter.sv | 137 +++++++++++++
 tb/tb_mt_bram_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mt_bram_arbiter.sv
// Round-robin arbiter giving eight channel requesters read access to one BRAM port,
// gated on a Mapping Table Header ready flag that is polled out of reset.
module mt_bram_arbiter #(
  parameter logic [31:0] HDR_ADDR = 32'h4580_0020,
  parameter int          NUM_CH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      req,
  input  logic [32*NUM_CH-1:0]   req_addr,
  output logic [NUM_CH-1:0]      gnt,
  output logic [NUM_CH-1:0]      rd_valid,
  output logic [31:0]            rd_data,
  output logic                   hdr_ready,
  output logic                   busy,
  output logic                   ram_clk,
  output logic                   ram_rst,
  output logic                   ram_en,
  output logic [3:0]             ram_we,
  output logic [31:0]            ram_wd_data,
  output logic [31:0]            ram_addr,
  input  logic [31:0]            ram_rd_data
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {POLL, ARB, ADDR, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [31:0]         ram_addr_q, ram_addr_d;
  logic [31:0]         hdr_word_q, hdr_word_d;
  logic                hdr_ready_q, hdr_ready_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic [NUM_CH-1:0]   rd_valid_q, rd_valid_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                busy_q, busy_d;
  logic [CH_W-1:0]     last_gnt_q, last_gnt_d;

  logic [CH_W-1:0]     sel;
  logic                found;
  logic [31:0]         sel_addr;

  // Scan from last_gnt+1 upward; the CH_W-bit add wraps 7->0 on its own.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      logic [CH_W-1:0] idx;
      idx = last_gnt_q + CH_W'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign sel_addr = req_addr[{sel, 5'd0} +: 32];

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    hdr_word_d  = hdr_word_q;
    hdr_ready_d = hdr_ready_q;
    gnt_d       = '0;
    rd_valid_d  = '0;
    rd_data_d   = rd_data_q;
    busy_d      = busy_q;
    last_gnt_d  = last_gnt_q;
    case (state_q)
      POLL: begin
        ram_addr_d = HDR_ADDR;
        hdr_word_d = ram_rd_data;
        if (hdr_word_q == 32'd1) begin
          hdr_ready_d = 1'b1;
          state_d     = ARB;
        end
      end
      ARB: begin
        if (found) begin
          ram_addr_d = sel_addr & ~32'h3;
          last_gnt_d = sel;
          gnt_d      = {{(NUM_CH-1){1'b0}}, 1'b1} << sel;
          busy_d     = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: state_d = WAIT;
      WAIT: begin
        rd_data_d  = ram_rd_data;
        rd_valid_d = {{(NUM_CH-1){1'b0}}, 1'b1} << last_gnt_q;
        state_d    = RESP;
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = ARB;
      end
      default: state_d = POLL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= POLL;
      ram_addr_q  <= HDR_ADDR;
      hdr_word_q  <= '0;
      hdr_ready_q <= 1'b0;
      gnt_q       <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      last_gnt_q  <= '1;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      hdr_word_q  <= hdr_word_d;
      hdr_ready_q <= hdr_ready_d;
      gnt_q       <= gnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign hdr_ready   = hdr_ready_q;
  assign busy        = busy_q;
  assign ram_addr    = ram_addr_q;
  assign ram_clk     = clk;
  assign ram_rst     = rst;
  assign ram_en      = 1'b1;
  assign ram_we      = '0;
  assign ram_wd_data = '0;

endmodule

// File: tb/tb_mt_bram_arbiter.sv
// Directed + randomized bench for mt_bram_arbiter against a transaction-level
// schedule model (cycle -> expected grant / data / busy) and a behavioural BRAM.
module tb_mt_bram_arbiter;

  localparam logic [31:0] HDR = 32'h4580_0020;
  localparam int          INF = 32'h3fff_ffff;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   req;
  logic [255:0] req_addr;
  logic [7:0]   gnt, rd_valid;
  logic [31:0]  rd_data, ram_wd_data, ram_addr, ram_rd_data;
  logic         hdr_ready, busy, ram_clk, ram_rst, ram_en;
  logic [3:0]   ram_we;
  logic [31:0]  hdr_val;

  mt_bram_arbiter #(.HDR_ADDR(HDR), .NUM_CH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .hdr_ready(hdr_ready), .busy(busy),
    .ram_clk(ram_clk), .ram_rst(ram_rst), .ram_en(ram_en), .ram_we(ram_we),
    .ram_wd_data(ram_wd_data), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bram_word(input logic [31:0] a);
    if (a == 32'h4580_0100) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h3C3C_C3C3;
  endfunction

  // One-cycle-latency BRAM; the header word is controlled by the bench.
  always @(posedge clk) ram_rd_data <= (ram_addr == HDR) ? hdr_val : bram_word(ram_addr);

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: expected outputs keyed by cycle number.
  bit          polling;
  int          hdr_cycle, free_cycle, last_m;
  logic [7:0]  exp_gnt [int];
  logic [7:0]  exp_rv  [int];
  logic [31:0] exp_data[int];
  logic [31:0] exp_ra  [int];
  bit          exp_busy[int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    polling = 1'b1; hdr_cycle = INF; free_cycle = INF; last_m = 7;
  endtask

  task automatic model_cycle();
    if (rst) begin
      model_reset();
      for (int t = cyc + 1; t <= cyc + 4; t++) begin
        if (exp_gnt.exists(t))  exp_gnt.delete(t);
        if (exp_rv.exists(t))   exp_rv.delete(t);
        if (exp_data.exists(t)) exp_data.delete(t);
        if (exp_ra.exists(t))   exp_ra.delete(t);
        if (exp_busy.exists(t)) exp_busy.delete(t);
      end
    end else if (polling) begin
      if (ram_rd_data == 32'd1) begin
        polling = 1'b0; hdr_cycle = cyc + 2; free_cycle = cyc + 2;
      end
    end else if (cyc >= free_cycle && req != 8'h00) begin
      for (int k = 1; k <= 8; k++) begin
        int ch;
        ch = (last_m + k) % 8;
        if (req[ch]) begin
          logic [31:0] a;
          a = req_addr[ch*32 +: 32];
          a[1:0] = 2'b00;
          exp_gnt[cyc+1]  = 8'(1 << ch);
          exp_ra[cyc+1]   = a;
          exp_rv[cyc+3]   = 8'(1 << ch);
          exp_data[cyc+3] = bram_word(a);
          for (int t = 1; t <= 3; t++) exp_busy[cyc+t] = 1'b1;
          last_m = ch;
          free_cycle = cyc + 4;
          break;
        end
      end
    end
  endtask

  task automatic check_cycle();
    logic [7:0] eg, erv;
    eg  = exp_gnt.exists(cyc) ? exp_gnt[cyc] : 8'h00;
    erv = exp_rv.exists(cyc)  ? exp_rv[cyc]  : 8'h00;
    chk("gnt", {24'd0, gnt}, {24'd0, eg});
    chk("rd_valid", {24'd0, rd_valid}, {24'd0, erv});
    if (erv != 8'h00) chk("rd_data", rd_data, exp_data[cyc]);
    chk("busy", {31'd0, busy}, {31'd0, exp_busy.exists(cyc)});
    chk("hdr_ready", {31'd0, hdr_ready}, {31'd0, (cyc >= hdr_cycle)});
    if (exp_ra.exists(cyc)) chk("ram_addr", ram_addr, exp_ra[cyc]);
  endtask

  task automatic step();
    model_cycle();
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    step();
    while (gnt == 8'h00 && n < 12) begin step(); n++; end
    chk({tag, "_gnt_seen"}, {31'd0, (gnt != 8'h00)}, 32'd1);
  endtask

  initial begin
    logic [7:0] gq[$];
    int         gc[$];
    int         n, cnt80;
    logic [7:0] first;

    rst = 1'b1; req = 8'h00; hdr_val = 32'd0; ram_rd_data = 32'd0;
    for (int i = 0; i < 8; i++) req_addr[i*32 +: 32] = 32'h4580_1000 + 32'($urandom_range(0, 4095));
    model_reset();

    // Reset state
    step(); step();
    chk("rst_ram_addr", ram_addr, HDR);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_ram_rst", {31'd0, ram_rst}, 32'd1);
    chk("ram_en", {31'd0, ram_en}, 32'd1);
    chk("ram_we", {28'd0, ram_we}, 32'd0);
    chk("ram_wd_data", ram_wd_data, 32'd0);

    // Header wait with all channels requesting
    rst = 1'b0; req = 8'hFF;
    for (int i = 0; i < 10; i++) step();
    hdr_val = 32'd1;
    n = 0;
    while (hdr_ready !== 1'b1 && n < 10) begin step(); n++; end
    chk("hdr_rise_delay", n, 32'd3);

    // Round robin with req held at FF
    for (int i = 0; i < 45; i++) begin
      step();
      if (gnt != 8'h00) begin gq.push_back(gnt); gc.push_back(cyc); end
    end
    chk("rr_count_ge9", {31'd0, (gq.size() >= 9)}, 32'd1);
    for (int k = 0; k < 9 && k < gq.size(); k++) begin
      chk("rr_order", {24'd0, gq[k]}, 32'(1 << (k % 8)));
      if (k > 0) chk("rr_spacing", gc[k] - gc[k-1], 32'd4);
    end

    // Single read
    req = 8'h00;
    for (int i = 0; i < 6; i++) step();
    req_addr[2*32 +: 32] = 32'h4580_0100; req = 8'h04;
    wait_gnt("single");
    req = 8'h00;
    chk("single_gnt", {24'd0, gnt}, 32'h04);
    chk("single_ram_addr", ram_addr, 32'h4580_0100);
    step(); step();
    chk("single_rd_valid", {24'd0, rd_valid}, 32'h04);
    chk("single_rd_data", rd_data, 32'hDEAD_BEEF);

    // Withdrawal and wrap: last grant 6, then 7 requested and dropped before arbitration
    for (int i = 0; i < 4; i++) step();
    req = 8'h40;
    wait_gnt("ch6");
    chk("ch6_gnt", {24'd0, gnt}, 32'h40);
    req = 8'h81;
    step();
    req = 8'h01;
    cnt80 = 0; first = 8'h00;
    for (int i = 0; i < 12; i++) begin
      step();
      if (gnt == 8'h80) cnt80++;
      if (gnt != 8'h00 && first == 8'h00) begin first = gnt; req = 8'h00; end
    end
    chk("withdraw_no80", cnt80, 32'd0);
    chk("withdraw_next", {24'd0, first}, 32'h01);

    // Unaligned address
    req_addr[0 +: 32] = 32'h4580_0103; req = 8'h01;
    wait_gnt("unal");
    req = 8'h00;
    chk("unal_ram_addr", ram_addr, 32'h4580_0100);
    for (int i = 0; i < 4; i++) step();

    // Reset during WAIT
    req_addr[1*32 +: 32] = 32'h4580_1234; req = 8'h02;
    wait_gnt("rstw");
    req = 8'h00;
    step();
    chk("rstw_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_rd_valid", {24'd0, rd_valid}, 32'd0);
    chk("rstw_ram_addr", ram_addr, HDR);
    chk("rstw_hdr_ready", {31'd0, hdr_ready}, 32'd0);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    step(); step(); step();
    rst = 1'b0;

    // Randomized traffic from well-behaved requesters
    for (int i = 0; i < 500; i++) begin
      step();
      for (int c = 0; c < 8; c++) begin
        if (gnt[c]) req[c] = 1'b0;
        else if (req[c] && $urandom_range(0, 39) == 0) req[c] = 1'b0;
        else if (!req[c] && $urandom_range(0, 3) == 0) begin
          req_addr[c*32 +: 32] = 32'h4580_1000 + 32'($urandom_range(0, 4095));
          req[c] = 1'b1;
        end
      end
    end
    req = 8'h00;
    for (int i = 0; i < 6; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
